// File: rtl/iter_alu_if.sv
// Operand/result bundle for iter_alu: valid/ready operand handshake on the way in,
// result strobe plus flags on the way out.
interface iter_alu_if #(
   parameter int unsigned WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       opcode;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] accum;
   logic             out_valid;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] alu_out_hi;
   logic             zero;
   logic             carry;
   logic             overflow;
   logic             negative;

   modport master (
      output in_valid, opcode, data, accum,
      input  in_ready, out_valid, alu_out, alu_out_hi, zero, carry, overflow, negative
   );

   modport slave (
      input  in_valid, opcode, data, accum,
      output in_ready, out_valid, alu_out, alu_out_hi, zero, carry, overflow, negative
   );
endinterface

// File: rtl/iter_alu.sv
// Accumulator ALU: single-cycle arithmetic/logic ops plus a WIDTH-cycle shift-add multiplier
// producing a full double-width product, with registered results and flags.
module iter_alu #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MUL_SIGNED = 1'b0
) (
   input logic        clk,
   input logic        reset,
   iter_alu_if.slave  bus
);
   localparam int unsigned     CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   localparam logic [2:0] OpPassA = 3'b000;
   localparam logic [2:0] OpAdd   = 3'b001;
   localparam logic [2:0] OpSub   = 3'b010;
   localparam logic [2:0] OpAnd   = 3'b011;
   localparam logic [2:0] OpXor   = 3'b100;
   localparam logic [2:0] OpAbs   = 3'b101;
   localparam logic [2:0] OpMul   = 3'b110;

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e state_q, state_d;

   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   alu_out_q, alu_out_d;
   logic [WIDTH-1:0]   alu_out_hi_q, alu_out_hi_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               overflow_q, overflow_d;
   logic               negative_q, negative_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               sign_q, sign_d;

   logic               accept;
   logic               mul_start;
   logic               mul_last;
   logic               a_msb;
   logic               d_msb;
   logic [WIDTH:0]     add_w;
   logic [WIDTH:0]     sub_w;
   logic [WIDTH-1:0]   a_neg;
   logic [WIDTH-1:0]   d_neg;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_nx;
   logic [2*WIDTH-1:0] prod_res;

   assign bus.in_ready = (state_q == StIdle) & ~reset;
   assign accept       = bus.in_valid & bus.in_ready;
   assign mul_start    = accept & (bus.opcode == OpMul);
   assign mul_last     = (state_q == StMul) && (cnt_q == CntLast);

   assign a_msb = bus.accum[WIDTH-1];
   assign d_msb = bus.data[WIDTH-1];
   assign add_w = {1'b0, bus.accum} + {1'b0, bus.data};
   // Top bit of the widened difference is the unsigned borrow.
   assign sub_w = {1'b0, bus.accum} - {1'b0, bus.data};
   assign a_neg = '0 - bus.accum;
   assign d_neg = '0 - bus.data;

   // Right-shifting product: the upper half accumulates, retired bits fall into the lower half.
   assign mul_addend = mplier_q[0] ? mcand_q : '0;
   assign mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   assign prod_nx    = {mul_sum, prod_q[WIDTH-1:1]};
   assign prod_res   = (MUL_SIGNED && sign_q) ? ('0 - prod_nx) : prod_nx;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (mul_start) state_d = StMul;
         StMul:  if (mul_last)  state_d = StIdle;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         alu_out_q    <= '0;
         alu_out_hi_q <= '0;
         zero_q       <= 1'b0;
         carry_q      <= 1'b0;
         overflow_q   <= 1'b0;
         negative_q   <= 1'b0;
         cnt_q        <= '0;
         prod_q       <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         sign_q       <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         alu_out_q    <= alu_out_d;
         alu_out_hi_q <= alu_out_hi_d;
         zero_q       <= zero_d;
         carry_q      <= carry_d;
         overflow_q   <= overflow_d;
         negative_q   <= negative_d;
         cnt_q        <= cnt_d;
         prod_q       <= prod_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         sign_q       <= sign_d;
      end
   end

   // Output / datapath next-value logic
   always_comb begin
      out_valid_d  = 1'b0;
      alu_out_d    = alu_out_q;
      alu_out_hi_d = alu_out_hi_q;
      zero_d       = zero_q;
      carry_d      = carry_q;
      overflow_d   = overflow_q;
      negative_d   = negative_q;
      cnt_d        = cnt_q;
      prod_d       = prod_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      sign_d       = sign_q;

      if (state_q == StIdle) begin
         if (mul_start) begin
            cnt_d    = '0;
            prod_d   = '0;
            mcand_d  = (MUL_SIGNED && a_msb) ? a_neg : bus.accum;
            mplier_d = (MUL_SIGNED && d_msb) ? d_neg : bus.data;
            sign_d   = MUL_SIGNED & (a_msb ^ d_msb);
         end else if (accept) begin
            out_valid_d  = 1'b1;
            alu_out_hi_d = '0;
            carry_d      = 1'b0;
            overflow_d   = 1'b0;
            unique case (bus.opcode)
               OpPassA: alu_out_d = bus.accum;
               OpAdd: begin
                  alu_out_d  = add_w[WIDTH-1:0];
                  carry_d    = add_w[WIDTH];
                  overflow_d = (a_msb == d_msb) & (add_w[WIDTH-1] != a_msb);
               end
               OpSub: begin
                  alu_out_d  = sub_w[WIDTH-1:0];
                  carry_d    = sub_w[WIDTH];
                  overflow_d = (a_msb != d_msb) & (sub_w[WIDTH-1] != a_msb);
               end
               OpAnd:   alu_out_d = bus.accum & bus.data;
               OpXor:   alu_out_d = bus.accum ^ bus.data;
               OpAbs: begin
                  alu_out_d  = a_msb ? a_neg : bus.accum;
                  // Only the most-negative value negates to itself.
                  overflow_d = a_msb & a_neg[WIDTH-1];
               end
               default: alu_out_d = bus.data;
            endcase
            zero_d     = (alu_out_d == '0);
            negative_d = alu_out_d[WIDTH-1];
         end
      end else begin
         cnt_d    = cnt_q + CntW'(1);
         prod_d   = prod_nx;
         mplier_d = mplier_q >> 1;
         if (mul_last) begin
            out_valid_d  = 1'b1;
            alu_out_hi_d = prod_res[2*WIDTH-1:WIDTH];
            alu_out_d    = prod_res[WIDTH-1:0];
            zero_d       = (prod_res == '0);
            carry_d      = 1'b0;
            overflow_d   = MUL_SIGNED ?
                           (prod_res[2*WIDTH-1:WIDTH] != {WIDTH{prod_res[WIDTH-1]}}) :
                           (prod_res[2*WIDTH-1:WIDTH] != '0);
            negative_d   = prod_res[2*WIDTH-1];
         end
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.alu_out    = alu_out_q;
   assign bus.alu_out_hi = alu_out_hi_q;
   assign bus.zero       = zero_q;
   assign bus.carry      = carry_q;
   assign bus.overflow   = overflow_q;
   assign bus.negative   = negative_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: a vector table of single-cycle ops on an 8-bit instance, then
// multiply, busy-ignore and reset-abort sequences on 8-bit unsigned/signed and 16-bit instances.
module tb_iter_alu;
   localparam logic [2:0] OpPassA = 3'b000;
   localparam logic [2:0] OpAdd   = 3'b001;
   localparam logic [2:0] OpSub   = 3'b010;
   localparam logic [2:0] OpAnd   = 3'b011;
   localparam logic [2:0] OpXor   = 3'b100;
   localparam logic [2:0] OpAbs   = 3'b101;
   localparam logic [2:0] OpMul   = 3'b110;
   localparam logic [2:0] OpPassD = 3'b111;
   localparam int         NumVec  = 13;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] res;
      logic       z;
      logic       c;
      logic       v;
      logic       n;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   iter_alu_if #(.WIDTH(8))  if8u ();
   iter_alu_if #(.WIDTH(8))  if8s ();
   iter_alu_if #(.WIDTH(16)) if16 ();

   iter_alu #(.WIDTH(8), .MUL_SIGNED(1'b0)) u_alu8u (.clk(clk), .reset(reset), .bus(if8u));
   iter_alu #(.WIDTH(8), .MUL_SIGNED(1'b1)) u_alu8s (.clk(clk), .reset(reset), .bus(if8s));
   iter_alu #(.WIDTH(16), .MUL_SIGNED(1'b0)) u_alu16 (.clk(clk), .reset(reset), .bus(if16));

   int total = 0;
   int bad   = 0;
   int sel   = 0;
   vec_t vecs [NumVec];

   logic        m_valid, m_ready, m_z, m_c, m_v, m_n;
   logic [15:0] m_out, m_hi;

   always_comb begin
      m_valid = if8u.out_valid;
      m_ready = if8u.in_ready;
      m_out   = {8'h00, if8u.alu_out};
      m_hi    = {8'h00, if8u.alu_out_hi};
      m_z     = if8u.zero;
      m_c     = if8u.carry;
      m_v     = if8u.overflow;
      m_n     = if8u.negative;
      if (sel == 1) begin
         m_valid = if8s.out_valid;
         m_ready = if8s.in_ready;
         m_out   = {8'h00, if8s.alu_out};
         m_hi    = {8'h00, if8s.alu_out_hi};
         m_z     = if8s.zero;
         m_c     = if8s.carry;
         m_v     = if8s.overflow;
         m_n     = if8s.negative;
      end else if (sel == 2) begin
         m_valid = if16.out_valid;
         m_ready = if16.in_ready;
         m_out   = if16.alu_out;
         m_hi    = if16.alu_out_hi;
         m_z     = if16.zero;
         m_c     = if16.carry;
         m_v     = if16.overflow;
         m_n     = if16.negative;
      end
   end

   task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int which, input logic v, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] d);
      case (which)
         0: begin
            if8u.in_valid = v; if8u.opcode = op; if8u.accum = a[7:0]; if8u.data = d[7:0];
         end
         1: begin
            if8s.in_valid = v; if8s.opcode = op; if8s.accum = a[7:0]; if8s.data = d[7:0];
         end
         default: begin
            if16.in_valid = v; if16.opcode = op; if16.accum = a; if16.data = d;
         end
      endcase
   endtask

   // Accept a MUL, keep in_valid asserted with other operands while busy, then check timing
   // and the registered product/flags.
   task automatic run_mul(input int which, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_hi, input logic [15:0] exp_lo,
                          input logic exp_v, input logic exp_n, input int exp_lat);
      int lat;
      bit seen;
      sel = which;
      drive(which, 1'b1, OpMul, a, d);
      @(posedge clk); #1;
      drive(which, 1'b1, OpAdd, 16'h0001, 16'h0001);
      check_bit("mul_ready_after_accept", m_ready, 1'b0);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (m_valid) seen = 1'b1;
         else check_bit("mul_ready_busy", m_ready, 1'b0);
      end
      drive(which, 1'b0, OpPassA, 16'h0000, 16'h0000);
      check_int("mul_latency", lat, exp_lat);
      check_bit("mul_ready_at_result", m_ready, 1'b1);
      check_val("mul_hi", m_hi, exp_hi);
      check_val("mul_lo", m_out, exp_lo);
      check_bit("mul_ovf", m_v, exp_v);
      check_bit("mul_neg", m_n, exp_n);
      check_bit("mul_carry", m_c, 1'b0);
      check_bit("mul_zero", m_z, 1'b0);
      @(posedge clk); #1;
      check_bit("mul_no_queued_op", m_valid, 1'b0);
      check_val("mul_lo_held", m_out, exp_lo);
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{OpPassA, 8'hDF, 8'hD6, 8'hDF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{OpAdd,   8'hDF, 8'hD6, 8'hB5, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{OpSub,   8'hDF, 8'hD6, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{OpAnd,   8'hDF, 8'hD6, 8'hD6, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{OpXor,   8'hDF, 8'hD6, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{OpPassD, 8'hDF, 8'hD6, 8'hD6, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{OpAbs,   8'hDF, 8'hD6, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{OpAbs,   8'h80, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{OpSub,   8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{OpAdd,   8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{OpSub,   8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{OpSub,   8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{OpAdd,   8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

      for (int w = 0; w < 3; w++) drive(w, 1'b0, OpPassA, 16'h0000, 16'h0000);

      // Power-on reset
      repeat (2) begin @(posedge clk); #1; end
      sel = 0;
      check_bit("rst_out_valid", m_valid, 1'b0);
      check_val("rst_alu_out", m_out, 16'h0000);
      check_bit("rst_ready_low", m_ready, 1'b0);
      reset = 1'b0;
      #1;
      check_bit("ready_after_rst_8u", if8u.in_ready, 1'b1);
      check_bit("ready_after_rst_8s", if8s.in_ready, 1'b1);
      check_bit("ready_after_rst_16", if16.in_ready, 1'b1);

      // Back-to-back single-cycle ops
      for (int i = 0; i < NumVec; i++) begin
         drive(0, 1'b1, vecs[i].op, {8'h00, vecs[i].a}, {8'h00, vecs[i].d});
         @(posedge clk); #1;
         check_bit($sformatf("vec%0d_valid", i), m_valid, 1'b1);
         check_bit($sformatf("vec%0d_ready", i), m_ready, 1'b1);
         check_val($sformatf("vec%0d_out", i), m_out, {8'h00, vecs[i].res});
         check_val($sformatf("vec%0d_hi", i), m_hi, 16'h0000);
         check_bit($sformatf("vec%0d_zero", i), m_z, vecs[i].z);
         check_bit($sformatf("vec%0d_carry", i), m_c, vecs[i].c);
         check_bit($sformatf("vec%0d_ovf", i), m_v, vecs[i].v);
         check_bit($sformatf("vec%0d_neg", i), m_n, vecs[i].n);
      end
      drive(0, 1'b0, OpPassA, 16'h0000, 16'h0000);
      @(posedge clk); #1;
      check_bit("idle_no_valid", m_valid, 1'b0);
      check_val("idle_out_held", m_out, 16'h0000);

      run_mul(0, 16'h00DF, 16'h00D6, 16'h00BA, 16'h006A, 1'b1, 1'b1, 8);

      // Reset three cycles into a multiply aborts it
      sel = 0;
      drive(0, 1'b1, OpMul, 16'h00DF, 16'h00D6);
      @(posedge clk); #1;
      drive(0, 1'b0, OpPassA, 16'h0000, 16'h0000);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      check_bit("abort_valid_in_rst", m_valid, 1'b0);
      reset = 1'b0;
      #1;
      check_bit("abort_ready", m_ready, 1'b1);
      check_val("abort_out", m_out, 16'h0000);
      check_val("abort_hi", m_hi, 16'h0000);
      check_bit("abort_flags", m_z | m_c | m_v | m_n, 1'b0);
      pulses = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (m_valid) pulses++;
      end
      check_int("abort_no_valid", pulses, 0);
      drive(0, 1'b1, OpAdd, 16'h0001, 16'h0001);
      @(posedge clk); #1;
      drive(0, 1'b0, OpPassA, 16'h0000, 16'h0000);
      check_bit("post_abort_valid", m_valid, 1'b1);
      check_val("post_abort_add", m_out, 16'h0002);

      run_mul(1, 16'h00DF, 16'h00D6, 16'h0005, 16'h006A, 1'b1, 1'b0, 8);
      run_mul(1, 16'h00FF, 16'h0002, 16'h00FF, 16'h00FE, 1'b0, 1'b1, 8);
      run_mul(2, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b1, 1'b1, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test, want end of test");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
Parametrised successor to the 8-opcode accumulator ALU. It supports any operand width and adds a valid/ready input handshake and an output valid strobe. It adds full carry/overflow/negative flags and an iterative shift-add multiplier that produces a full WIDTH x WIDTH product over WIDTH cycles. It sits between the accumulator register and operand bus in the datapath; all other opcodes complete in one cycle.

Parameters:
WIDTH, 8, operand and result width in bits (>=4).
MUL_SIGNED, 0, 0 = unsigned multiply; 1 = two's-complement signed multiply (sign-magnitude around the shift-add core).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands/opcode present
in_ready  output  1  block can accept; equals (state==IDLE)
opcode  input  3  000 PASSA, 001 ADD, 010 SUB, 011 AND, 100 XOR, 101 ABS, 110 MUL, 111 PASSD
data  input  WIDTH  operand D
accum  input  WIDTH  operand A
out_valid  output  1  one-cycle strobe: result/flags updated
alu_out  output  WIDTH  result (low half for MUL)
alu_out_hi  output  WIDTH  MUL high half; 0 for all other ops
zero  output  1  result == 0 (full 2*WIDTH product for MUL)
carry  output  1  ADD carry-out / SUB borrow; 0 otherwise
overflow  output  1  signed overflow (see below)
negative  output  1  MSB of alu_out (MSB of alu_out_hi for MUL)

Behaviour:
- Reset (sync, dominates everything): state=IDLE; all outputs 0 except in_ready=1 once reset is low. Inputs are ignored while reset=1. Reset during MUL aborts the op; no out_valid is issued.
- Accept = in_valid & in_ready at a rising edge. opcode, data and accum are captured there; later input changes have no effect.
- Single-cycle ops accepted at edge E: results and flags are registered at E, and out_valid=1 for the cycle after E. State stays IDLE, so back-to-back accepts every cycle are allowed.
- PASSA: alu_out=accum. PASSD: alu_out=data.
- ADD: {carry,alu_out}=accum+data. overflow=(A[msb]==D[msb]) & (R[msb]!=A[msb]).
- SUB: alu_out=accum-data mod 2^WIDTH. carry=borrow (accum<data unsigned). overflow=(A[msb]!=D[msb]) & (R[msb]!=A[msb]).
- AND/XOR: bitwise; carry=0, overflow=0.
- ABS: signed |accum|. The most-negative input returns itself with overflow=1.
- MUL FSM, IDLE -> MUL -> IDLE:
  - Accept at E enters MUL, with counter=0 and product=0. Signed mode stores the operand magnitudes and sign = A[msb]^D[msb].
  - One partial-product add-and-shift per cycle, WIDTH iterations.
  - At edge E+WIDTH: write {alu_out_hi,alu_out} (negated if signed and sign=1), set flags, out_valid=1 for the following cycle, return to IDLE.
  - in_ready=0 from the cycle after E through edge E+WIDTH; in_ready=1 in the same cycle that out_valid is high.
  - MUL carry=0. overflow=1 if alu_out_hi is not the extension of alu_out (zero-extension unsigned, sign-extension signed).
- Between results, all outputs hold their last values; out_valid=0.
- in_valid while busy is ignored and not queued.

Test Plan:
- WIDTH=8, A=0xDF, D=0xD6, ops issued back-to-back: PASSA->0xDF; ADD->0xB5, carry1, ovf0, neg1; SUB->0x09, carry0; AND->0xD6; XOR->0x09; PASSD->0xD6. out_valid high every cycle, 1-cycle latency each.
- ABS A=0xDF->0x21, ovf0; ABS A=0x80->0x80, ovf1, neg1. SUB A=D=0x5A->0x00, zero1, carry0. ADD 0x7F+0x01->0x80, ovf1.
- MUL_SIGNED=0, A=0xDF, D=0xD6: hi=0xBA, lo=0x6A, ovf1, zero0. out_valid exactly 8 edges after accept; in_ready low for 8 cycles; a second in_valid during busy has no effect.
- MUL_SIGNED=1, same operands: hi=0x05, lo=0x6A, ovf1, neg0. A=0xFF, D=0x02 -> hi=0xFF, lo=0xFE, ovf0, neg1.
- Reset asserted 3 cycles after MUL accept: no out_valid ever; all outputs 0; in_ready=1 in the first cycle after reset drops. The next ADD 0x01+0x01 returns 0x02.
- WIDTH=16, MUL_SIGNED=0, A=0xFFFF, D=0xFFFF: hi=0xFFFE, lo=0x0001, out_valid 16 edges after accept.
